vga_line_scanout: RTL and testbench

- Downstream consumer of the AXI ping-pong line fetcher.
- Generates VGA raster timing and reads pixels out of the two line BRAMs (BRAM_1/BRAM_2) that the fetcher fills, alternating buffers every active line.
- Issues one fill request (VGA_READY pulse) per active line, tracks fill completion (AXI_VGA_READY), and flags underruns.
- Sits between the fetcher's BRAM write ports and the board VGA DAC pins.

---
 rtl/vga_line_scanout.sv | 243 ++++++++++++++++++++++++
 tb/tb_vga_line_scanout.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_line_scanout.sv
`timescale 1ns/1ps
// VGA raster generator that scans pixels out of two ping-pong line BRAMs,
// requesting a refill of each buffer as soon as its line has been read.
module vga_line_scanout #(
  parameter int PIXEL_WIDTH     = 16,
  parameter int BRAM_ADDR_WIDTH = 32,
  parameter int PIX_DIV         = 4,
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter bit SYNC_POL        = 1'b0
) (
  input  logic                       M_AXI_ACLK,
  input  logic                       M_AXI_ARESETN,
  output logic                       VGA_READY,
  input  logic                       AXI_VGA_READY,
  output logic [BRAM_ADDR_WIDTH-1:0] RD_ADDR,
  output logic                       RD_EN_1,
  output logic                       RD_EN_2,
  input  logic [PIXEL_WIDTH-1:0]     RD_DATA_1,
  input  logic [PIXEL_WIDTH-1:0]     RD_DATA_2,
  output logic [PIXEL_WIDTH-1:0]     PIXEL_OUT,
  output logic                       DE,
  output logic                       HSYNC,
  output logic                       VSYNC,
  output logic                       UNDERRUN
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = $clog2(PIX_DIV);
  localparam int HX = HW + 1;
  localparam int VX = VW + 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 32'd1);
  localparam logic [DW-1:0] D_ONE    = DW'(1'b1);
  localparam logic [HW-1:0] H_ONE    = HW'(1'b1);
  localparam logic [VW-1:0] V_ONE    = VW'(1'b1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 32'd1);
  localparam logic [HW-1:0] H_SWAP   = HW'(H_ACTIVE - 32'd1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 32'd1);
  // One extra bit so a sync window ending exactly at the total never wraps.
  localparam logic [HX-1:0] H_ACT_END  = HX'(H_ACTIVE);
  localparam logic [HX-1:0] H_SYNC_BEG = HX'(H_ACTIVE + H_FP);
  localparam logic [HX-1:0] H_SYNC_END = HX'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VX-1:0] V_ACT_END  = VX'(V_ACTIVE);
  localparam logic [VX-1:0] V_SYNC_BEG = VX'(V_ACTIVE + V_FP);
  localparam logic [VX-1:0] V_SYNC_END = VX'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [2:0] {
    PRIME_REQ1  = 3'd0,
    PRIME_WAIT1 = 3'd1,
    PRIME_REQ2  = 3'd2,
    PRIME_WAIT2 = 3'd3,
    RUN         = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [DW-1:0]              div_q;
  logic [HW-1:0]              hcnt_q;
  logic [VW-1:0]              vcnt_q;
  logic                       rd_sel_q, fill_busy_q, pend_q, underrun_q, vga_ready_q;
  logic                       fill_busy_d, pend_d, underrun_d;
  logic [BRAM_ADDR_WIDTH-1:0] rd_addr_q;
  logic                       rd_en1_q, rd_en2_q;
  logic                       act_p_q, hs_p_q, vs_p_q, sel_p_q;
  logic [PIXEL_WIDTH-1:0]     pixel_q;
  logic                       de_q, hsync_q, vsync_q;

  logic          pix_ce_s, run_s, active_s, hs_win_s, vs_win_s, swap_s;
  logic          ack_s, busy_eff_s, prime_issue_s, issue_s;
  logic [HX-1:0] hx_s;
  logic [VX-1:0] vx_s;

  assign pix_ce_s   = (div_q == DIV_LAST);
  assign run_s      = (state_q == RUN);
  assign hx_s       = {1'b0, hcnt_q};
  assign vx_s       = {1'b0, vcnt_q};
  assign active_s   = (hx_s < H_ACT_END) && (vx_s < V_ACT_END);
  assign hs_win_s   = (hx_s >= H_SYNC_BEG) && (hx_s < H_SYNC_END);
  assign vs_win_s   = (vx_s >= V_SYNC_BEG) && (vx_s < V_SYNC_END);
  assign swap_s     = run_s && pix_ce_s && (hcnt_q == H_SWAP) && (vx_s < V_ACT_END);
  // Acks are only meaningful while something is outstanding; stale ones are dropped.
  assign ack_s      = AXI_VGA_READY &&
                      ((state_q == PRIME_WAIT1) || (state_q == PRIME_WAIT2) || fill_busy_q);
  assign busy_eff_s = fill_busy_q && !ack_s;

  // Pixel clock-enable divider.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      div_q <= {DW{1'b0}};
    end else if (pix_ce_s) begin
      div_q <= {DW{1'b0}};
    end else begin
      div_q <= div_q + D_ONE;
    end
  end

  // State register.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q <= PRIME_REQ1;
    end else begin
      state_q <= state_d;
    end
  end

  // Priming sequence: fill both buffers once before the raster starts.
  always_comb begin
    state_d       = state_q;
    prime_issue_s = 1'b0;
    case (state_q)
      PRIME_REQ1: begin
        prime_issue_s = 1'b1;
        state_d       = PRIME_WAIT1;
      end
      PRIME_WAIT1: begin
        if (ack_s) state_d = PRIME_REQ2;
        else       state_d = PRIME_WAIT1;
      end
      PRIME_REQ2: begin
        prime_issue_s = 1'b1;
        state_d       = PRIME_WAIT2;
      end
      PRIME_WAIT2: begin
        if (ack_s) state_d = RUN;
        else       state_d = PRIME_WAIT2;
      end
      RUN:     state_d = RUN;
      default: state_d = PRIME_REQ1;
    endcase
  end

  // Fill request bookkeeping: completion is taken before a coincident swap.
  always_comb begin
    issue_s     = prime_issue_s || (run_s && (swap_s || pend_q) && !busy_eff_s);
    fill_busy_d = fill_busy_q;
    pend_d      = pend_q;
    underrun_d  = underrun_q;
    if (issue_s) begin
      fill_busy_d = 1'b1;
      pend_d      = 1'b0;
    end else if (ack_s) begin
      fill_busy_d = 1'b0;
    end else begin
      fill_busy_d = fill_busy_q;
    end
    if (swap_s && busy_eff_s) begin
      pend_d     = 1'b1;
      underrun_d = 1'b1;
    end else begin
      underrun_d = underrun_q;
    end
  end

  // Fill handshake registers.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      fill_busy_q <= 1'b0;
      pend_q      <= 1'b0;
      underrun_q  <= 1'b0;
      vga_ready_q <= 1'b0;
    end else begin
      fill_busy_q <= fill_busy_d;
      pend_q      <= pend_d;
      underrun_q  <= underrun_d;
      vga_ready_q <= issue_s;
    end
  end

  // Raster counters, frozen at the origin until both buffers are primed.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      hcnt_q <= {HW{1'b0}};
      vcnt_q <= {VW{1'b0}};
    end else if (!run_s) begin
      hcnt_q <= {HW{1'b0}};
      vcnt_q <= {VW{1'b0}};
    end else if (pix_ce_s) begin
      if (hcnt_q == H_LAST) begin
        hcnt_q <= {HW{1'b0}};
        vcnt_q <= (vcnt_q == V_LAST) ? {VW{1'b0}} : vcnt_q + V_ONE;
      end else begin
        hcnt_q <= hcnt_q + H_ONE;
      end
    end
  end

  // Two-stage read pipeline: stage 0 issues the BRAM read, stage 1 drives the DAC.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      rd_addr_q <= {BRAM_ADDR_WIDTH{1'b0}};
      rd_en1_q  <= 1'b0;
      rd_en2_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      act_p_q   <= 1'b0;
      hs_p_q    <= 1'b0;
      vs_p_q    <= 1'b0;
      sel_p_q   <= 1'b0;
      pixel_q   <= {PIXEL_WIDTH{1'b0}};
      de_q      <= 1'b0;
      hsync_q   <= ~SYNC_POL;
      vsync_q   <= ~SYNC_POL;
    end else begin
      rd_en1_q <= 1'b0;
      rd_en2_q <= 1'b0;
      if (pix_ce_s) begin
        act_p_q <= run_s && active_s;
        hs_p_q  <= run_s && hs_win_s;
        vs_p_q  <= run_s && vs_win_s;
        sel_p_q <= rd_sel_q;
        if (run_s && active_s) begin
          rd_addr_q <= BRAM_ADDR_WIDTH'(hcnt_q);
          rd_en1_q  <= ~rd_sel_q;
          rd_en2_q  <= rd_sel_q;
        end
        de_q    <= act_p_q;
        pixel_q <= act_p_q ? (sel_p_q ? RD_DATA_2 : RD_DATA_1) : {PIXEL_WIDTH{1'b0}};
        hsync_q <= hs_p_q ? SYNC_POL : ~SYNC_POL;
        vsync_q <= vs_p_q ? SYNC_POL : ~SYNC_POL;
      end
      if (swap_s) rd_sel_q <= ~rd_sel_q;
    end
  end

  assign VGA_READY = vga_ready_q;
  assign RD_ADDR   = rd_addr_q;
  assign RD_EN_1   = rd_en1_q;
  assign RD_EN_2   = rd_en2_q;
  assign PIXEL_OUT = pixel_q;
  assign DE        = de_q;
  assign HSYNC     = hsync_q;
  assign VSYNC     = vsync_q;
  assign UNDERRUN  = underrun_q;

endmodule

// File: tb/tb_vga_line_scanout.sv
`timescale 1ns/1ps
// Scoreboard bench for vga_line_scanout on a shrunken raster, with a BRAM
// model and a fetcher model whose ack latency is scripted per request.
module tb_vga_line_scanout;

  localparam int PW = 16, AW = 8, PD = 2;
  localparam int HA = 8, HF = 2, HS = 3, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int LINE_CLK  = (HA + HF + HS + HB) * PD;
  localparam int FRAME_CLK = LINE_CLK * (VA + VF + VS + VB);

  localparam logic [15:0] B1 [0:7] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004,
                                       16'h0005, 16'h0006, 16'h0007, 16'h0008};
  localparam logic [15:0] B2 [0:7] = '{16'hA0C3, 16'h1E5F, 16'h7B20, 16'h03D9,
                                       16'hF00F, 16'h4C71, 16'hBEEF, 16'h2468};

  logic          clk, rst_n, vga_ready, axi_vga_ready;
  logic [AW-1:0] rd_addr;
  logic          rd_en_1, rd_en_2;
  logic [PW-1:0] rd_data_1, rd_data_2, pixel_out;
  logic          de, hsync, vsync, underrun;

  vga_line_scanout #(
    .PIXEL_WIDTH(PW), .BRAM_ADDR_WIDTH(AW), .PIX_DIV(PD),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .VGA_READY(vga_ready), .AXI_VGA_READY(axi_vga_ready),
    .RD_ADDR(rd_addr), .RD_EN_1(rd_en_1), .RD_EN_2(rd_en_2),
    .RD_DATA_1(rd_data_1), .RD_DATA_2(rd_data_2),
    .PIXEL_OUT(pixel_out), .DE(de), .HSYNC(hsync), .VSYNC(vsync), .UNDERRUN(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Line BRAMs with one clock of read latency.
  initial begin
    rd_data_1 = 16'h0000;
    rd_data_2 = 16'h0000;
  end
  always @(posedge clk) begin
    if (rd_en_1) rd_data_1 <= B1[rd_addr[2:0]];
    if (rd_en_2) rd_data_2 <= B2[rd_addr[2:0]];
  end

  typedef struct { logic [15:0] pix; int rel; } exp_t;
  exp_t sb_q[$];

  int n_total, n_bad;
  int req_cnt, ack_cnt, last_ack_cyc;
  bit mon_on;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input int f);
    exp_t e;
    for (int l = 0; l < VA; l++) begin
      for (int p = 0; p < HA; p++) begin
        e.pix = (((3 * f + l) % 2) == 1) ? B2[p] : B1[p];
        e.rel = f * FRAME_CLK + l * LINE_CLK + p * PD;
        sb_q.push_back(e);
      end
    end
  endtask

  function automatic int ack_delay(input int r);
    case (r)
      8:       return 27;   // ack lands on the next swap clock
      11:      return 40;   // ack lands after the next swap
      default: return 20;
    endcase
  endfunction

  function automatic bit next_pulse(input int r);
    return (r == 8) || (r == 11) || (r == 12);
  endfunction

  // Fetcher model: acks each request after a scripted delay.
  bit exp_pending, exp_next;
  initial begin
    int d;
    bit en;
    axi_vga_ready = 1'b0;
    exp_pending = 1'b0;
    exp_next = 1'b0;
    req_cnt = 0;
    ack_cnt = 0;
    last_ack_cyc = 0;
    forever begin
      @(negedge clk);
      if (exp_pending) begin
        chk($sformatf("pulse_after_ack%0d", ack_cnt - 1), vga_ready, exp_next);
        exp_pending = 1'b0;
      end
      if (vga_ready && rst_n) begin
        d = ack_delay(req_cnt);
        en = next_pulse(req_cnt);
        req_cnt++;
        repeat (d) @(posedge clk);
        #1 axi_vga_ready = 1'b1;
        @(posedge clk);
        #1 axi_vga_ready = 1'b0;
        last_ack_cyc = cyc;
        ack_cnt++;
        exp_next = en;
        exp_pending = 1'b1;
      end
    end
  end

  // Monitor: pixel scoreboard plus timing and read-enable observations.
  int  ready_cnt, en1_cnt, en2_cnt, base, de_rise, hs_fall;
  bit  first_de, prev_de, prev_hs, prev_vs;
  logic [15:0] prev_pix;

  task automatic rearm();
    ready_cnt = 0; en1_cnt = 0; en2_cnt = 0;
    base = 0; de_rise = -100000; hs_fall = -1;
    first_de = 1'b0; prev_de = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1;
    prev_pix = 16'h0000;
  endtask

  initial begin
    int rel, dl;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (rd_en_1 || rd_en_2) chk("rd_en_exclusive", rd_en_1 & rd_en_2, 0);
        if (ready_cnt < 3) begin
          if (rd_en_1) en1_cnt++;
          if (rd_en_2) en2_cnt++;
        end
        if (de) begin
          if (!first_de) begin
            first_de = 1'b1;
            base = cyc;
            dl = cyc - last_ack_cyc;
            chk("ready_pulses_before_de", ready_cnt, 2);
            chk("first_de_latency_in_range", (dl >= PD + 1) && (dl <= 2 * PD), 1);
          end
          rel = cyc - base;
          if (!prev_de) begin
            de_rise = cyc;
            chk("de_rise_aligned", rel % PD, 0);
          end
          if ((rel % PD) == 0) begin
            if (sb_q.size() == 0) begin
              chk("sb_unexpected_pixel", 1, 0);
            end else begin
              e = sb_q.pop_front();
              chk("pixel_value", pixel_out, e.pix);
              chk("pixel_time", rel, e.rel);
            end
          end else begin
            chk("pixel_hold", pixel_out, prev_pix);
          end
        end else begin
          chk("pixel_zero_blank", pixel_out, 0);
        end
        if (prev_hs && !hsync) begin
          hs_fall = cyc;
          if (cyc - de_rise < LINE_CLK) chk("hsync_start", cyc - de_rise, (HA + HF) * PD);
        end
        if (!prev_hs && hsync && hs_fall >= 0) chk("hsync_len", cyc - hs_fall, HS * PD);
        if (prev_vs && !vsync && first_de)
          chk("vsync_start", (cyc - base) % FRAME_CLK, (VA + VF) * LINE_CLK);
        if (vga_ready) begin
          ready_cnt++;
          if (ready_cnt == 3) begin
            chk("line0_rd_en_1", en1_cnt, HA);
            chk("line0_rd_en_2", en2_cnt, 0);
          end
        end
        prev_de = de; prev_pix = pixel_out; prev_hs = hsync; prev_vs = vsync;
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_vga_ready"}, vga_ready, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_rd_en"}, {rd_en_1, rd_en_2}, 0);
    chk({tag, "_pixel"}, pixel_out, 0);
    chk({tag, "_de"}, de, 0);
    chk({tag, "_syncs"}, {hsync, vsync}, 2'b11);
    chk({tag, "_underrun"}, underrun, 0);
  endtask

  task automatic wait_acks(input int n);
    int k;
    k = 0;
    while (ack_cnt < n && k < 4000) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("reached_ack_%0d", n), ack_cnt >= n, 1);
  endtask

  initial begin
    int k;
    n_total = 0;
    n_bad = 0;
    mon_on = 1'b0;
    rearm();
    rst_n = 1'b0;
    for (int f = 0; f < 5; f++) push_frame(f);
    repeat (3) @(negedge clk);
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    mon_on = 1'b1;
    @(negedge clk);
    chk("ready_after_release", vga_ready, 1);

    wait_acks(11);
    chk("no_underrun_after_coincident_ack", underrun, 0);
    wait_acks(14);
    chk("underrun_set", underrun, 1);
    wait_acks(15);
    chk("underrun_held", underrun, 1);

    k = 0;
    while (!de && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("de_before_midline_reset", de, 1);
    @(negedge clk);
    mon_on = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset("midline_reset");
    sb_q.delete();
    rearm();
    push_frame(0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mon_on = 1'b1;
    @(negedge clk);
    chk("ready_after_rerelease", vga_ready, 1);

    k = 0;
    while (sb_q.size() != 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("restart_frame_drained", sb_q.size(), 0);
    chk("underrun_clear_after_reset", underrun, 0);
    repeat (2 * LINE_CLK) @(negedge clk);
    chk("no_extra_pixels", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
